// File: rtl/operand_issue.sv
// -----------------------------------------------------------------------------
// operand_issue
//   Operand-read / issue stage sitting between decode and the calculation units.
//   Holds the architectural register file and a per-register pending
//   scoreboard, forwards same-cycle write-back data into the operand read,
//   stalls decode on RAW/WAW hazards and issues through a one-entry registered
//   valid/ready output stage.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  drop the held output entry (and its pending mark)
//   in_valid / in_ready    decode handshake
//   in_ctrl                {unit, sub_unit, sel}, passed through
//   in_rs1_v/_ad           rs1 read request / address
//   in_rs2_v/_ad           rs2 read request / address
//   in_rd_v/_ad            destination request / address
//   in_use_pc, in_pc       rs1 operand replaced by pc (rs1 neither read nor checked)
//   in_imm, in_immediate   immediate flag / value, passed through
//   out_valid / out_ready  unit handshake
//   out_*                  registered issue entry
//   wb_valid/adr/data      NWB write-back channels, higher index wins
// -----------------------------------------------------------------------------
module operand_issue #(
  parameter int  XLEN = 32,
  parameter int  NREG = 32,
  parameter int  NWB  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8:0]          in_ctrl,
  input  logic                in_rs1_v,
  input  logic [AW-1:0]       in_rs1_ad,
  input  logic                in_rs2_v,
  input  logic [AW-1:0]       in_rs2_ad,
  input  logic                in_rd_v,
  input  logic [AW-1:0]       in_rd_ad,
  input  logic                in_use_pc,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                in_imm,
  input  logic [XLEN-1:0]     in_immediate,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8:0]          out_ctrl,
  output logic [XLEN-1:0]     out_rs1,
  output logic [XLEN-1:0]     out_rs2,
  output logic                out_rd_v,
  output logic [AW-1:0]       out_rd_ad,
  output logic                out_imm,
  output logic [XLEN-1:0]     out_immediate,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*AW-1:0]   wb_adr,
  input  logic [NWB*XLEN-1:0] wb_data
);

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic [NREG-1:0] wb_hit;

  logic [XLEN-1:0] rs1_p0;
  logic [XLEN-1:0] rs2_p0;
  logic            rs1_pend;
  logic            rs2_pend;
  logic            rd_pend;
  logic            hazard;
  logic            accept;
  logic            kill;

  logic            vld_p1;
  logic [8:0]      ctrl_p1;
  logic [XLEN-1:0] rs1_p1;
  logic [XLEN-1:0] rs2_p1;
  logic            rd_v_p1;
  logic [AW-1:0]   rd_ad_p1;
  logic            imm_p1;
  logic [XLEN-1:0] immediate_p1;

  // ---- stage p0: operand read, bypass, hazard detection ----
  // Registers receiving a write-back this cycle; x0 is never marked.
  always_comb begin
    wb_hit = '0;
    for (int a = 1; a < NREG; a++) begin
      for (int i = 0; i < NWB; i++) begin
        if (wb_valid[i] && (wb_adr[i*AW +: AW] == AW'(a))) wb_hit[a] = 1'b1;
      end
    end
  end

  // Ascending channel scan: the last match (highest index) overrides the file.
  always_comb begin
    rs1_p0 = '0;
    if (in_use_pc) begin
      rs1_p0 = in_pc;
    end else if (in_rs1_v && (in_rs1_ad != '0)) begin
      rs1_p0 = rf[in_rs1_ad];
      for (int i = 0; i < NWB; i++) begin
        if (wb_valid[i] && (wb_adr[i*AW +: AW] == in_rs1_ad)) rs1_p0 = wb_data[i*XLEN +: XLEN];
      end
    end
    rs2_p0 = '0;
    if (in_rs2_v && (in_rs2_ad != '0)) begin
      rs2_p0 = rf[in_rs2_ad];
      for (int i = 0; i < NWB; i++) begin
        if (wb_valid[i] && (wb_adr[i*AW +: AW] == in_rs2_ad)) rs2_p0 = wb_data[i*XLEN +: XLEN];
      end
    end
  end

  // A register being written back this cycle no longer blocks: its value is bypassed.
  assign rs1_pend = in_rs1_v && !in_use_pc && pending[in_rs1_ad] && !wb_hit[in_rs1_ad];
  assign rs2_pend = in_rs2_v && pending[in_rs2_ad] && !wb_hit[in_rs2_ad];
  assign rd_pend  = in_rd_v && pending[in_rd_ad] && !wb_hit[in_rd_ad];
  assign hazard   = in_valid && (rs1_pend || rs2_pend || rd_pend);

  assign in_ready = (!vld_p1 || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  // A flushed entry that targets a register had marked it pending on accept.
  assign kill     = flush && vld_p1 && rd_v_p1;

  // Clears first, then set, so a same-cycle set of the same register wins.
  always_comb begin
    pending_nxt = pending & ~wb_hit;
    if (kill) pending_nxt[rd_ad_p1] = 1'b0;
    if (accept && in_rd_v) pending_nxt[in_rd_ad] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  // Later channels are assigned last, so the highest index wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < NREG; a++) rf[a] <= '0;
    end else begin
      for (int i = 0; i < NWB; i++) begin
        if (wb_valid[i] && (wb_adr[i*AW +: AW] != '0)) rf[wb_adr[i*AW +: AW]] <= wb_data[i*XLEN +: XLEN];
      end
    end
  end

  // ---- stage p1: registered issue entry ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      ctrl_p1      <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_v_p1      <= 1'b0;
      rd_ad_p1     <= '0;
      imm_p1       <= 1'b0;
      immediate_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (!vld_p1 || out_ready) begin
      vld_p1 <= accept;
      if (accept) begin
        ctrl_p1      <= in_ctrl;
        rs1_p1       <= rs1_p0;
        rs2_p1       <= rs2_p0;
        rd_v_p1      <= in_rd_v;
        rd_ad_p1     <= in_rd_ad;
        imm_p1       <= in_imm;
        immediate_p1 <= in_immediate;
      end
    end
  end

  assign out_valid     = vld_p1;
  assign out_ctrl      = ctrl_p1;
  assign out_rs1       = rs1_p1;
  assign out_rs2       = rs2_p1;
  assign out_rd_v      = rd_v_p1;
  assign out_rd_ad     = rd_ad_p1;
  assign out_imm       = imm_p1;
  assign out_immediate = immediate_p1;

endmodule

// File: tb/tb_operand_issue.sv
module tb_operand_issue;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NWB  = 2;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [8:0]      in_ctrl;
  logic            in_rs1_v;
  logic [AW-1:0]   in_rs1_ad;
  logic            in_rs2_v;
  logic [AW-1:0]   in_rs2_ad;
  logic            in_rd_v;
  logic [AW-1:0]   in_rd_ad;
  logic            in_use_pc;
  logic [XLEN-1:0] in_pc;
  logic            in_imm;
  logic [XLEN-1:0] in_immediate;
  logic            out_valid;
  logic            out_ready;
  logic [8:0]      out_ctrl;
  logic [XLEN-1:0] out_rs1;
  logic [XLEN-1:0] out_rs2;
  logic            out_rd_v;
  logic [AW-1:0]   out_rd_ad;
  logic            out_imm;
  logic [XLEN-1:0] out_immediate;
  logic [NWB-1:0]      wb_valid;
  logic [NWB*AW-1:0]   wb_adr;
  logic [NWB*XLEN-1:0] wb_data;

  operand_issue #(.XLEN(XLEN), .NREG(NREG), .NWB(NWB)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_rs1_v(in_rs1_v), .in_rs1_ad(in_rs1_ad),
    .in_rs2_v(in_rs2_v), .in_rs2_ad(in_rs2_ad),
    .in_rd_v(in_rd_v), .in_rd_ad(in_rd_ad),
    .in_use_pc(in_use_pc), .in_pc(in_pc),
    .in_imm(in_imm), .in_immediate(in_immediate),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd_v(out_rd_v), .out_rd_ad(out_rd_ad),
    .out_imm(out_imm), .out_immediate(out_immediate),
    .wb_valid(wb_valid), .wb_adr(wb_adr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_rf [NREG];
  logic            m_pend [NREG];
  logic            m_vld;
  logic [47:0]     m_misc;   // {ctrl, rd_v, rd_ad, imm, immediate}
  logic [XLEN-1:0] m_rs1, m_rs2;
  logic            m_rd_v;
  logic [AW-1:0]   m_rd_ad;

  function automatic void model_reset();
    for (int a = 0; a < NREG; a++) begin m_rf[a] = '0; m_pend[a] = 1'b0; end
    m_vld = 1'b0; m_misc = '0; m_rs1 = '0; m_rs2 = '0; m_rd_v = 1'b0; m_rd_ad = '0;
  endfunction

  function automatic logic [AW-1:0] ch_adr(input int i);
    return wb_adr[i*AW +: AW];
  endfunction

  function automatic logic wb_to(input logic [AW-1:0] a);
    for (int i = 0; i < NWB; i++) if (wb_valid[i] && ch_adr(i) == a) return 1'b1;
    return 1'b0;
  endfunction

  // Highest active channel matching wins, otherwise the file; x0 reads zero.
  function automatic logic [XLEN-1:0] read_op(input logic [AW-1:0] a);
    if (a == '0) return '0;
    for (int i = NWB - 1; i >= 0; i--)
      if (wb_valid[i] && ch_adr(i) == a) return wb_data[i*XLEN +: XLEN];
    return m_rf[a];
  endfunction

  function automatic logic pend_now(input logic [AW-1:0] a);
    return (a != '0) && m_pend[a] && !wb_to(a);
  endfunction

  function automatic logic model_ready();
    logic hz;
    hz = in_valid && ((in_rs1_v && !in_use_pc && pend_now(in_rs1_ad)) ||
                      (in_rs2_v && pend_now(in_rs2_ad)) ||
                      (in_rd_v && pend_now(in_rd_ad)));
    return (!m_vld || out_ready) && !hz && !flush;
  endfunction

  function automatic void model_step(input logic rdy);
    logic acc;
    logic [XLEN-1:0] op1, op2;
    acc = in_valid && rdy;
    op1 = in_use_pc ? in_pc : (in_rs1_v ? read_op(in_rs1_ad) : '0);
    op2 = in_rs2_v ? read_op(in_rs2_ad) : '0;
    for (int i = 0; i < NWB; i++) if (wb_valid[i]) m_pend[ch_adr(i)] = 1'b0;
    if (flush && m_vld && m_rd_v) m_pend[m_rd_ad] = 1'b0;
    if (acc && in_rd_v && in_rd_ad != '0) m_pend[in_rd_ad] = 1'b1;
    for (int i = 0; i < NWB; i++)
      if (wb_valid[i] && ch_adr(i) != '0) m_rf[ch_adr(i)] = wb_data[i*XLEN +: XLEN];
    if (flush) m_vld = 1'b0;
    else if (!m_vld || out_ready) begin
      m_vld = acc;
      if (acc) begin
        m_rs1 = op1; m_rs2 = op2; m_rd_v = in_rd_v; m_rd_ad = in_rd_ad;
        m_misc = {in_ctrl, in_rd_v, in_rd_ad, in_imm, in_immediate};
      end
    end
  endfunction

  // One clock: in_ready sampled mid-cycle, outputs sampled just after the edge.
  task automatic tick(output logic rdy);
    logic exp_rdy;
    @(negedge clk);
    rdy = in_ready;
    exp_rdy = model_ready();
    chk("model_in_ready", 64'(in_ready), 64'(exp_rdy));
    model_step(exp_rdy);
    @(posedge clk);
    #1;
    chk("model_out_valid", 64'(out_valid), 64'(m_vld));
    if (m_vld) begin
      chk("model_out_rs1", 64'(out_rs1), 64'(m_rs1));
      chk("model_out_rs2", 64'(out_rs2), 64'(m_rs2));
      chk("model_out_misc", 64'({out_ctrl, out_rd_v, out_rd_ad, out_imm, out_immediate}), 64'(m_misc));
    end
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; in_ctrl = '0; in_rs1_v = 0; in_rs1_ad = '0;
    in_rs2_v = 0; in_rs2_ad = '0; in_rd_v = 0; in_rd_ad = '0; in_use_pc = 0;
    in_pc = '0; in_imm = 0; in_immediate = '0; out_ready = 1;
    wb_valid = '0; wb_adr = '0; wb_data = '0;
  endtask

  task automatic set_instr(input logic r1v, input logic [4:0] r1, input logic r2v,
                           input logic [4:0] r2, input logic rdv, input logic [4:0] rd);
    in_valid = 1; in_rs1_v = r1v; in_rs1_ad = r1; in_rs2_v = r2v; in_rs2_ad = r2;
    in_rd_v = rdv; in_rd_ad = rd; in_use_pc = 0;
  endtask

  typedef struct {
    logic [1:0] wbv; logic [4:0] wa0; logic [31:0] wd0; logic [4:0] wa1; logic [31:0] wd1;
    logic iv; logic r1v; logic [4:0] r1; logic r2v; logic [4:0] r2;
    logic rdv; logic [4:0] rd; logic upc; logic [31:0] pc;
    logic erdy; logic eov; logic [31:0] ers1; logic [31:0] ers2;
  } vec_t;

  vec_t vecs[$];
  logic rdy;

  initial begin
    // wbv wa0 wd0 wa1 wd1 | iv r1v r1 r2v r2 rdv rd upc pc | erdy eov ers1 ers2
    vecs.push_back('{2'b01, 5'd5, 32'h1234, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,    32'h0});
    vecs.push_back('{2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h1234, 32'h0});
    vecs.push_back('{2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,    32'h0});
    vecs.push_back('{2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0});
    vecs.push_back('{2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0});
    vecs.push_back('{2'b10, 5'd0, 32'h0,    5'd3, 32'hAA, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hAA,   32'h0});
    vecs.push_back('{2'b11, 5'd7, 32'h11,   5'd7, 32'h22, 1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h22,   32'h22});
    vecs.push_back('{2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b1, 5'd7, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h22,   32'h1234});
    vecs.push_back('{2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,    32'hAA});
    vecs.push_back('{2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,    32'h0});
    vecs.push_back('{2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h80,  1'b1, 1'b1, 32'h80,   32'h0});
    vecs.push_back('{2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,    32'h0});
    vecs.push_back('{2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h100,  32'h0});
    vecs.push_back('{2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0});
    vecs.push_back('{2'b01, 5'd0, 32'hDEAD, 5'd0, 32'h0,  1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,    32'h0});
    vecs.push_back('{2'b01, 5'd4, 32'h44,   5'd0, 32'h0,  1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 32'h0,   1'b1, 1'b1, 32'h44,   32'h0});
    vecs.push_back('{2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    32'h0});
    vecs.push_back('{2'b10, 5'd0, 32'h0,    5'd4, 32'h55, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,    32'h0});
    vecs.push_back('{2'b00, 5'd0, 32'h0,    5'd0, 32'h0,  1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h55,   32'h0});

    // Reset state
    clear_inputs();
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'({out_ctrl, out_rd_v, out_rd_ad, out_imm}), 64'(0));
    chk("rst_out_rs", {out_rs1, out_rs2}, 64'(0));
    chk("rst_out_immediate", 64'(out_immediate), 64'(0));
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Table-driven vectors: bypass, RAW stall, channel priority, x0, use_pc
    for (int i = 0; i < vecs.size(); i++) begin
      wb_valid = vecs[i].wbv;
      wb_adr = {vecs[i].wa1, vecs[i].wa0};
      wb_data = {vecs[i].wd1, vecs[i].wd0};
      set_instr(vecs[i].r1v, vecs[i].r1, vecs[i].r2v, vecs[i].r2, vecs[i].rdv, vecs[i].rd);
      in_valid = vecs[i].iv;
      in_use_pc = vecs[i].upc;
      in_pc = vecs[i].pc;
      in_ctrl = 9'(i + 1);
      in_imm = 1'(i);
      in_immediate = $urandom;
      out_ready = 1; flush = 0;
      tick(rdy);
      chk($sformatf("vec%0d_in_ready", i), 64'(rdy), 64'(vecs[i].erdy));
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].eov));
      if (vecs[i].eov) begin
        chk($sformatf("vec%0d_out_rs1", i), 64'(out_rs1), 64'(vecs[i].ers1));
        chk($sformatf("vec%0d_out_rs2", i), 64'(out_rs2), 64'(vecs[i].ers2));
      end
    end
    clear_inputs();

    // Back-pressure: held entry (rs1=0x55) stays put for 3 cycles
    set_instr(1, 5'd5, 0, 5'd0, 1, 5'd6);
    in_ctrl = 9'h1A5;
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick(rdy);
      chk("hold_in_ready", 64'(rdy), 64'(0));
      chk("hold_out_valid", 64'(out_valid), 64'(1));
      chk("hold_out_rs1", 64'(out_rs1), 64'(32'h55));
    end
    out_ready = 1;
    tick(rdy);
    chk("release_in_ready", 64'(rdy), 64'(1));
    chk("release_out_rs1", 64'(out_rs1), 64'(32'h1234));
    chk("release_out_rd_ad", 64'(out_rd_ad), 64'(6));
    chk("release_out_ctrl", 64'(out_ctrl), 64'(9'h1A5));
    set_instr(1, 5'd7, 0, 5'd0, 0, 5'd0);
    tick(rdy);
    chk("stream1_out_rs1", 64'({out_valid, out_rs1}), 64'({1'b1, 32'h22}));
    set_instr(1, 5'd3, 0, 5'd0, 0, 5'd0);
    tick(rdy);
    chk("stream2_out_rs1", 64'({out_valid, out_rs1}), 64'({1'b1, 32'hAA}));

    // Flush of a held entry that marked x9 pending
    set_instr(0, 5'd0, 0, 5'd0, 1, 5'd9);
    tick(rdy);
    chk("f_issue_rd9", 64'({out_valid, out_rd_ad}), 64'({1'b1, 5'd9}));
    in_valid = 0; out_ready = 0;
    tick(rdy);
    chk("f_held", 64'(out_valid), 64'(1));
    flush = 1;
    set_instr(1, 5'd9, 0, 5'd0, 0, 5'd0);
    tick(rdy);
    chk("f_flush_in_ready", 64'(rdy), 64'(0));
    chk("f_flush_out_valid", 64'(out_valid), 64'(0));
    flush = 0;
    tick(rdy);
    chk("f_after_in_ready", 64'(rdy), 64'(1));
    chk("f_after_out", 64'({out_valid, out_rs1}), 64'({1'b1, 32'h0}));
    clear_inputs();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      wb_valid = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
      wb_adr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wb_data = {$urandom, $urandom};
      in_valid = ($urandom_range(0, 9) < 7);
      in_ctrl = 9'($urandom);
      in_rs1_v = $urandom_range(0, 1) == 1; in_rs1_ad = 5'($urandom_range(0, 7));
      in_rs2_v = $urandom_range(0, 1) == 1; in_rs2_ad = 5'($urandom_range(0, 7));
      in_rd_v = $urandom_range(0, 2) != 0;  in_rd_ad = 5'($urandom_range(0, 7));
      in_use_pc = ($urandom_range(0, 9) == 0);
      in_pc = $urandom;
      in_imm = $urandom_range(0, 1) == 1;
      in_immediate = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      if (flush) out_ready = 0;
      tick(rdy);
    end
    clear_inputs();

    // Reset in the middle of traffic discards everything
    set_instr(1, 5'd3, 0, 5'd0, 1, 5'd2);
    tick(rdy);
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_out_rs", {out_rs1, out_rs2}, 64'(0));
    model_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    set_instr(1, 5'd3, 1, 5'd2, 0, 5'd0);
    tick(rdy);
    chk("post_rst_in_ready", 64'(rdy), 64'(1));
    chk("post_rst_out", {out_valid, out_rs1[30:0], out_rs2}, {1'b1, 31'h0, 32'h0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
